// File: rtl/aes_pkg.sv
// Shared AES-128 types, constants and GF(2^8) helpers for the word-serial cores.
package aes_pkg;

  localparam int unsigned NR = 10;
  localparam int unsigned NK = 4;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_KEY,
    LOAD_CT,
    EXPAND,
    ARK0,
    ROUND,
    DONE,
    READ
  } aes_inv_state_t;

  localparam logic [7:0] RCON [1:10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[3'(i)]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (square-and-multiply); 0 maps to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    r = a;
    for (int unsigned i = 0; i < 6; i++) r = gmul(gmul(r, r), a);
    return gmul(r, r);
  endfunction

  function automatic logic [7:0] sub_byte(input logic [7:0] b);
    logic [7:0] i;
    i = gf_inv(b);
    return i ^ {i[6:0], i[7]} ^ {i[5:0], i[7:6]} ^ {i[4:0], i[7:5]} ^ {i[3:0], i[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sub_byte(input logic [7:0] s);
    return gf_inv({s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05);
  endfunction

  // Byte k of the state sits at bits [127-8k -: 8]; row = k%4, column = k/4.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int unsigned c = 0; c < 4; c++)
      for (int unsigned r = 0; r < 4; r++)
        o[7'(8 * (15 - (r + 4 * c))) +: 8] = s[7'(8 * (15 - (r + 4 * ((c + 4 - r) % 4)))) +: 8];
    return o;
  endfunction

  function automatic logic [31:0] inv_mix_column(input logic [31:0] col);
    logic [7:0]  a [4];
    logic [31:0] o;
    for (int unsigned i = 0; i < 4; i++) a[2'(i)] = col[5'(8 * (3 - i)) +: 8];
    o = '0;
    for (int unsigned i = 0; i < 4; i++)
      o[5'(8 * (3 - i)) +: 8] = gmul(a[2'(i)], 8'h0e) ^ gmul(a[2'(i + 1)], 8'h0b) ^
                                gmul(a[2'(i + 2)], 8'h0d) ^ gmul(a[2'(i + 3)], 8'h09);
    return o;
  endfunction

endpackage

// File: rtl/inv_s_box.sv
// Inverse AES S-box on four bytes of a 32-bit word.
module inv_s_box
  import aes_pkg::*;
(
  input  logic [31:0] din,
  output logic [31:0] dout
);

  // Independent inverse byte substitution.
  always_comb begin
    dout = '0;
    for (int unsigned i = 0; i < 4; i++) dout[5'(8 * i) +: 8] = inv_sub_byte(din[5'(8 * i) +: 8]);
  end

endmodule

// File: rtl/s_box.sv
// Forward AES S-box on four bytes of a 32-bit word.
module s_box
  import aes_pkg::*;
(
  input  logic [31:0] din,
  output logic [31:0] dout
);

  // Independent byte substitution.
  always_comb begin
    dout = '0;
    for (int unsigned i = 0; i < 4; i++) dout[5'(8 * i) +: 8] = sub_byte(din[5'(8 * i) +: 8]);
  end

endmodule

// File: rtl/aes_inv.sv
// Word-serial AES-128 decryptor: load key + ciphertext, expand schedule,
// one inverse round per cycle, then 32-bit plaintext readout.
module aes_inv
  import aes_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start_n,
  input  logic        start_read_n,
  input  logic [31:0] dword_in,
  output logic [31:0] dword_out,
  output logic        done
);

  localparam logic [5:0] LAST_WORD = 6'(NK * (NR + 1) - 1);
  localparam logic [5:0] RK10_BASE = 6'(NK * NR);

  aes_inv_state_t state, state_nxt;

  logic [31:0]  w [NK * (NR + 1)];
  logic [127:0] st;
  logic [5:0]   wcnt;
  logic [3:0]   rnd;
  logic [1:0]   col;

  logic [31:0]  w_prev, w_old, sw_in, sw_out, new_word;
  logic [5:0]   rk_base;
  logic [127:0] rk, isr, isb, ark, rnd_out;

  s_box u_sbox (.din(sw_in), .dout(sw_out));

  assign isr = inv_shift_rows(st);

  inv_s_box u_isb0 (.din(isr[31:0]),   .dout(isb[31:0]));
  inv_s_box u_isb1 (.din(isr[63:32]),  .dout(isb[63:32]));
  inv_s_box u_isb2 (.din(isr[95:64]),  .dout(isb[95:64]));
  inv_s_box u_isb3 (.din(isr[127:96]), .dout(isb[127:96]));

  // Next schedule word from w[i-1] and w[i-4].
  always_comb begin
    w_prev = w[wcnt - 6'd1];
    w_old  = w[wcnt - 6'd4];
    sw_in  = {w_prev[23:0], w_prev[31:24]};
    if (wcnt[1:0] == 2'b00) new_word = w_old ^ sw_out ^ {RCON[wcnt[5:2]], 24'h0};
    else                    new_word = w_old ^ w_prev;
  end

  // Round key select and one inverse round (mix skipped on the last round).
  always_comb begin
    rk_base = (state == ARK0) ? RK10_BASE : {rnd, 2'b00};
    rk      = {w[rk_base], w[rk_base + 6'd1], w[rk_base + 6'd2], w[rk_base + 6'd3]};
    ark     = isb ^ rk;
    rnd_out = ark;
    if (rnd != '0)
      for (int unsigned c = 0; c < 4; c++)
        rnd_out[7'(32 * c) +: 32] = inv_mix_column(ark[7'(32 * c) +: 32]);
  end

  // Next-state decode; start_n outranks start_read_n in DONE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (!start_n) state_nxt = LOAD_KEY;
      LOAD_KEY: if (wcnt == 6'd3) state_nxt = LOAD_CT;
      LOAD_CT:  if (col == 2'd3) state_nxt = EXPAND;
      EXPAND:   if (wcnt == LAST_WORD) state_nxt = ARK0;
      ARK0:     state_nxt = ROUND;
      ROUND:    if (rnd == '0) state_nxt = DONE;
      DONE: begin
        if (!start_n)           state_nxt = LOAD_KEY;
        else if (!start_read_n) state_nxt = READ;
      end
      READ:     if (col == 2'd3) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // State register and registered done flag.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= (state_nxt == DONE) || (state_nxt == READ);
    end
  end

  // Load, key-expansion and round datapath.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      st   <= '0;
      wcnt <= '0;
      rnd  <= '0;
      col  <= '0;
      for (int unsigned i = 0; i < NK * (NR + 1); i++) w[i] <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (state_nxt == LOAD_KEY) begin
            w[0] <= dword_in;
            wcnt <= 6'd1;
          end else if (state_nxt == READ) begin
            col <= 2'd1;
          end
        end
        LOAD_KEY: begin
          w[wcnt] <= dword_in;
          wcnt    <= wcnt + 6'd1;
          col     <= '0;
        end
        LOAD_CT: begin
          st[{2'd3 - col, 5'd0} +: 32] <= dword_in;
          col <= col + 2'd1;
        end
        EXPAND: begin
          w[wcnt] <= new_word;
          if (wcnt == LAST_WORD) begin
            wcnt <= '0;
            rnd  <= 4'(NR - 1);
          end else begin
            wcnt <= wcnt + 6'd1;
          end
        end
        ARK0: st <= st ^ rk;
        ROUND: begin
          st <= rnd_out;
          if (rnd != '0) rnd <= rnd - 4'd1;
        end
        READ: col <= col + 2'd1;
        default: ;
      endcase
    end
  end

  // Plaintext column selected by the read counter, zero outside readout.
  always_comb begin
    dword_out = '0;
    if (state == DONE || state == READ) dword_out = st[{2'd3 - col, 5'd0} +: 32];
  end

endmodule

// File: tb/tb_aes_inv.sv
// Self-checking bench for aes_inv: FIPS-197 vectors, control corner cases and
// random blocks against a byte-level behavioural AES model.
module tb_aes_inv;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start_n = 1'b1;
  logic        start_read_n = 1'b1;
  logic [31:0] dword_in = '0;
  logic [31:0] dword_out;
  logic        done;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  logic [7:0] sbox  [256];
  logic [7:0] isbox [256];

  localparam logic [127:0] C1_KEY  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_RK10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] B_KEY   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT    = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT    = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_RK10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  localparam logic [7:0] IMC [4][4] = '{
    '{8'h0e, 8'h0b, 8'h0d, 8'h09},
    '{8'h09, 8'h0e, 8'h0b, 8'h0d},
    '{8'h0d, 8'h09, 8'h0e, 8'h0b},
    '{8'h0b, 8'h0d, 8'h09, 8'h0e}
  };

  aes_inv dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start_n      (start_n),
    .start_read_n (start_read_n),
    .dword_in     (dword_in),
    .dword_out    (dword_out),
    .done         (done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // Carry-less product then polynomial reduction by 0x11B.
  function automatic logic [7:0] mul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ ({8'h00, a} << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
    return p[7:0];
  endfunction

  task automatic build_tables();
    logic [7:0] inv, s, xb, c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      xb  = 8'(x);
      inv = '0;
      for (int y = 1; y < 256; y++) if (mul(xb, 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^ inv[(i + 6) % 8] ^ inv[(i + 7) % 8] ^ c[i];
      sbox[x]  = s;
      isbox[s] = xb;
    end
  endtask

  task automatic model(input logic [127:0] key, input logic [127:0] ct,
                       output logic [127:0] rk10, output logic [127:0] pt);
    logic [31:0] mw [44];
    logic [7:0]  s [16];
    logic [7:0]  t [16];
    logic [7:0]  rc;
    logic [31:0] tmp;
    for (int i = 0; i < 4; i++) mw[i] = key[127 - 32 * i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = mw[i - 1];
      if (i % 4 == 0) begin
        tmp = {sbox[tmp[23:16]], sbox[tmp[15:8]], sbox[tmp[7:0]], sbox[tmp[31:24]]} ^ {rc, 24'h0};
        rc  = mul(rc, 8'h02);
      end
      mw[i] = mw[i - 4] ^ tmp;
    end
    rk10 = {mw[40], mw[41], mw[42], mw[43]};
    for (int k = 0; k < 16; k++) s[k] = ct[127 - 8 * k -: 8] ^ mw[40 + k / 4][31 - 8 * (k % 4) -: 8];
    for (int rd = 9; rd >= 0; rd--) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) t[r + 4 * ((c + r) % 4)] = s[r + 4 * c];
      for (int k = 0; k < 16; k++) s[k] = isbox[t[k]] ^ mw[4 * rd + k / 4][31 - 8 * (k % 4) -: 8];
      if (rd != 0) begin
        for (int c = 0; c < 4; c++)
          for (int r = 0; r < 4; r++) begin
            t[4 * c + r] = '0;
            for (int j = 0; j < 4; j++) t[4 * c + r] = t[4 * c + r] ^ mul(IMC[r][j], s[4 * c + j]);
          end
        for (int k = 0; k < 16; k++) s[k] = t[k];
      end
    end
    for (int k = 0; k < 16; k++) pt[127 - 8 * k -: 8] = s[k];
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents key word 0 with start_n low; the following edge is cycle T.
  task automatic start_op(input logic [31:0] k0);
    start_n  = 1'b0;
    dword_in = k0;
    tick();
    start_n  = 1'b1;
    dword_in = $urandom;
  endtask

  task automatic load_rest(input logic [127:0] key, input logic [127:0] ct);
    for (int i = 1; i < 4; i++) begin dword_in = key[127 - 32 * i -: 32]; tick(); end
    for (int i = 0; i < 4; i++) begin dword_in = ct[127 - 32 * i -: 32]; tick(); end
    dword_in = $urandom;
  endtask

  // Entered just after edge T+7; lat = index of the first edge that samples done high.
  task automatic wait_done(input bit noise, output int lat, output bit leak);
    lat  = 0;
    leak = 1'b0;
    for (int n = 8; n < 150; n++) begin
      if (noise && n < 40) begin
        start_n      = 1'($urandom_range(0, 1));
        start_read_n = 1'($urandom_range(0, 1));
      end else begin
        start_n      = 1'b1;
        start_read_n = 1'b1;
      end
      tick();
      if (done === 1'b1) begin lat = n + 1; break; end
      if (dword_out !== '0) leak = 1'b1;
    end
    start_n      = 1'b1;
    start_read_n = 1'b1;
  endtask

  task automatic read_out(input bit noise, output logic [127:0] pt, output bit tail_ok);
    pt[127:96]   = dword_out;
    start_read_n = 1'b0;
    tick();
    start_read_n = 1'b1;
    for (int i = 1; i < 4; i++) begin
      pt[127 - 32 * i -: 32] = dword_out;
      if (noise) begin
        start_n      = 1'($urandom_range(0, 1));
        start_read_n = 1'($urandom_range(0, 1));
      end
      tick();
    end
    start_n      = 1'b1;
    start_read_n = 1'b1;
    tail_ok = (done === 1'b0) && (dword_out === '0);
  endtask

  task automatic run_op(input logic [127:0] key, input logic [127:0] ct, input bit noise,
                        output int lat, output bit leak, output logic [127:0] rk10,
                        output logic [127:0] pt, output bit tail_ok);
    start_op(key[127:96]);
    load_rest(key, ct);
    wait_done(noise, lat, leak);
    rk10 = {dut.w[40], dut.w[41], dut.w[42], dut.w[43]};
    read_out(noise, pt, tail_ok);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n  = 1'b0;
    start_n  = 1'b0;
    dword_in = $urandom;
    repeat (3) tick();
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", done); end
    n_vec++; if (dword_out !== '0) begin n_err++; $display("FAIL reset_dout got %h want 0", dword_out); end
    n_vec++; if (dut.st !== '0) begin n_err++; $display("FAIL reset_state got %h want 0", dut.st); end
    start_n = 1'b1;
    reset_n = 1'b1;
    tick();
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL idle_done got %b want 0", done); end
  endtask

  task automatic test_fips_c1();
    int lat; bit leak, tail; logic [127:0] rk10, pt;
    run_op(C1_KEY, C1_CT, 1'b0, lat, leak, rk10, pt, tail);
    n_vec++; if (lat != 59) begin n_err++; $display("FAIL c1_latency got %0d want 59", lat); end
    n_vec++; if (leak) begin n_err++; $display("FAIL c1_dout_busy got nonzero want 0"); end
    n_vec++; if (rk10 !== C1_RK10) begin n_err++; $display("FAIL c1_rk10 got %h want %h", rk10, C1_RK10); end
    n_vec++; if (pt !== C1_PT) begin n_err++; $display("FAIL c1_pt got %h want %h", pt, C1_PT); end
    n_vec++; if (!tail) begin n_err++; $display("FAIL c1_tail got done=%b dout=%h want 0/0", done, dword_out); end
  endtask

  task automatic test_fips_b();
    int lat; bit leak, tail; logic [127:0] rk10, pt;
    run_op(B_KEY, B_CT, 1'b0, lat, leak, rk10, pt, tail);
    n_vec++; if (lat != 59) begin n_err++; $display("FAIL b_latency got %0d want 59", lat); end
    n_vec++; if (rk10 !== B_RK10) begin n_err++; $display("FAIL b_rk10 got %h want %h", rk10, B_RK10); end
    n_vec++; if (pt !== B_PT) begin n_err++; $display("FAIL b_pt got %h want %h", pt, B_PT); end
  endtask

  task automatic test_reset_mid_round();
    int lat; bit leak, tail; logic [127:0] rk10, pt;
    start_op(C1_KEY[127:96]);
    load_rest(C1_KEY, C1_CT);
    repeat (45) tick();
    n_vec++; if (dut.rnd !== 4'd5) begin n_err++; $display("FAIL midround_r got %0d want 5", dut.rnd); end
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL midround_done got %b want 0", done); end
    n_vec++; if (dword_out !== '0) begin n_err++; $display("FAIL midround_dout got %h want 0", dword_out); end
    n_vec++; if (dut.rnd !== '0 || dut.wcnt !== '0) begin n_err++; $display("FAIL midround_cnt got r=%0d w=%0d want 0/0", dut.rnd, dut.wcnt); end
    n_vec++; if (dut.w[40] !== '0) begin n_err++; $display("FAIL midround_key got %h want 0", dut.w[40]); end
    run_op(C1_KEY, C1_CT, 1'b0, lat, leak, rk10, pt, tail);
    n_vec++; if (lat != 59) begin n_err++; $display("FAIL after_reset_latency got %0d want 59", lat); end
    n_vec++; if (pt !== C1_PT) begin n_err++; $display("FAIL after_reset_pt got %h want %h", pt, C1_PT); end
  endtask

  task automatic test_ignored_inputs();
    int lat; bit leak, tail; logic [127:0] rk10, pt;
    run_op(C1_KEY, C1_CT, 1'b1, lat, leak, rk10, pt, tail);
    n_vec++; if (lat != 59) begin n_err++; $display("FAIL noise_latency got %0d want 59", lat); end
    n_vec++; if (leak) begin n_err++; $display("FAIL noise_dout_busy got nonzero want 0"); end
    n_vec++; if (pt !== C1_PT) begin n_err++; $display("FAIL noise_pt got %h want %h", pt, C1_PT); end
    n_vec++; if (!tail) begin n_err++; $display("FAIL noise_tail got done=%b dout=%h want 0/0", done, dword_out); end
  endtask

  task automatic test_simultaneous();
    int lat; bit leak, tail; logic [127:0] pt;
    start_op(C1_KEY[127:96]);
    load_rest(C1_KEY, C1_CT);
    wait_done(1'b0, lat, leak);
    n_vec++; if (dword_out !== C1_PT[127:96]) begin n_err++; $display("FAIL simul_p0 got %h want %h", dword_out, C1_PT[127:96]); end
    start_read_n = 1'b0;
    start_op(B_KEY[127:96]);
    start_read_n = 1'b1;
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL simul_done got %b want 0", done); end
    n_vec++; if (dword_out !== '0) begin n_err++; $display("FAIL simul_dout got %h want 0", dword_out); end
    load_rest(B_KEY, B_CT);
    wait_done(1'b0, lat, leak);
    n_vec++; if (lat != 59) begin n_err++; $display("FAIL simul_latency got %0d want 59", lat); end
    read_out(1'b0, pt, tail);
    n_vec++; if (pt !== B_PT) begin n_err++; $display("FAIL simul_pt got %h want %h", pt, B_PT); end
  endtask

  task automatic test_back_to_back();
    int lat; bit leak, tail; logic [127:0] rk10, pt;
    run_op(C1_KEY, C1_CT, 1'b0, lat, leak, rk10, pt, tail);
    n_vec++; if (pt !== C1_PT) begin n_err++; $display("FAIL b2b_first_pt got %h want %h", pt, C1_PT); end
    run_op(B_KEY, B_CT, 1'b0, lat, leak, rk10, pt, tail);
    n_vec++; if (lat != 59) begin n_err++; $display("FAIL b2b_latency got %0d want 59", lat); end
    n_vec++; if (rk10 !== B_RK10) begin n_err++; $display("FAIL b2b_rk10 got %h want %h", rk10, B_RK10); end
    n_vec++; if (pt !== B_PT) begin n_err++; $display("FAIL b2b_pt got %h want %h", pt, B_PT); end
  endtask

  task automatic test_random();
    int lat; bit leak, tail; logic [127:0] key, ct, rk10, pt, exp_rk10, exp_pt;
    for (int it = 0; it < 4; it++) begin
      key = {$urandom, $urandom, $urandom, $urandom};
      ct  = {$urandom, $urandom, $urandom, $urandom};
      model(key, ct, exp_rk10, exp_pt);
      run_op(key, ct, it[0], lat, leak, rk10, pt, tail);
      n_vec++; if (lat != 59) begin n_err++; $display("FAIL rand%0d_latency got %0d want 59", it, lat); end
      n_vec++; if (rk10 !== exp_rk10) begin n_err++; $display("FAIL rand%0d_rk10 got %h want %h", it, rk10, exp_rk10); end
      n_vec++; if (pt !== exp_pt) begin n_err++; $display("FAIL rand%0d_pt got %h want %h", it, pt, exp_pt); end
      n_vec++; if (!tail) begin n_err++; $display("FAIL rand%0d_tail got done=%b dout=%h want 0/0", it, done, dword_out); end
    end
  endtask

  initial begin
    build_tables();
    test_reset();
    test_fips_c1();
    test_fips_b();
    test_reset_mid_round();
    test_ignored_inputs();
    test_simultaneous();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/aes_inv.md
# aes_inv

Word-serial AES-128 decryption core: the inverse cipher that pairs with the team's `aes` encryptor. It uses the same 32-bit load/readout handshake, so either core can sit behind the same bus adapter. It loads a 128-bit key and one ciphertext block, expands and stores all 11 round keys, and runs the inverse cipher at one round per cycle. It then presents the plaintext for word-serial readout.

## Interface
- Parameters: none. Nr=10 and Nk=4 are fixed constants in `aes_pkg`.
- `clk` in 1: single clock. All state changes on the rising edge.
- `reset_n` in 1: reset is synchronous and active-low.
- `start_n` in 1: active-low start. Sampled only in IDLE or DONE.
- `start_read_n` in 1: active-low request to begin plaintext readout. Sampled only in DONE.
- `dword_in` in 32: key words, then ciphertext columns. Byte [31:24] is the lowest-numbered byte.
- `dword_out` out 32: plaintext column. Zero outside DONE and READ.
- `done` out 1: high in DONE and READ only.

## Operation
- States: IDLE, LOAD_KEY, LOAD_CT, EXPAND, ARK0, ROUND, DONE, READ.
- IDLE: `start_n` low at cycle T captures key word w0 from `dword_in` at T, then goes to LOAD_KEY.
- LOAD_KEY: captures w1..w3 at T+1..T+3.
- LOAD_CT: captures ciphertext columns c0..c3 at T+4..T+7 into the 128-bit state register.
- EXPAND: computes one schedule word per cycle, w4..w43, at T+8..T+47.
  - Words are stored in a 44x32 register array.
  - For i%4==0: w[i] = w[i-4] ^ SubWord(RotWord(w[i-1])) ^ Rcon[i/4].
  - Otherwise: w[i] = w[i-4] ^ w[i-1].
  - SubWord uses the existing forward `s_box` (one 32-bit instance).
- ARK0 (T+48): state ^= round key 10 (w40..w43).
- ROUND: 4-bit round counter r runs 9 down to 0, one round per cycle, at T+49..T+58.
  - Each round: InvShiftRows -> InvSubBytes (16 byte lookups) -> AddRoundKey(rk r).
  - InvMixColumns follows, except when r==0.
  - At r==0, go to DONE.
- DONE (from T+59): `done`=1 and `dword_out`=p0.
  - `start_read_n` low at cycle R: go to READ. The reader takes p0 at cycle R.
  - `start_n` low in DONE: abandons the readout and starts a new load exactly as from IDLE. `done` drops next cycle.
- READ: `dword_out`=p1 at R+1, p2 at R+2, p3 at R+3.
  - At R+4 the block is in IDLE with `done`=0 and `dword_out`=0.
- Ignored inputs:
  - `start_n` in LOAD_KEY..ROUND and in READ.
  - `start_read_n` outside DONE.
  - `dword_in` outside the load states.
- A `start_n` held low across several cycles counts as a single start.
- The key is not retained across operations; every start reloads 4 key words.

## Timing
- Reset (`reset_n` low at an edge, in any state, including mid-load or mid-round):
  - Next cycle: IDLE, `done`=0, `dword_out`=0, round and word counters 0.
  - State register and key array are cleared to 0.
- Latency: from the `start_n` sample (T) to `done` high is exactly 59 cycles (T+59).
- Full transaction: 8 load cycles + 40 EXPAND + 1 ARK0 + 10 ROUND + readout.
- `dword_out` is a combinational mux of the state register indexed by the read counter, gated by state. It never glitches to key material.
- `done` is registered and decoded from state.
- Simultaneous `start_n` and `start_read_n` low in DONE: `start_n` wins, a new load begins, and no readout occurs.
- Round counter wrap: r decrements from 9 to 0 and never underflows; the exit is decoded at r==0.
- Word counter runs 4..43; the exit is decoded at 43.
- All arithmetic is GF(2^8) on 8-bit bytes, with reduction polynomial 0x11B.

## Structure
- `aes_pkg` holds:
  - the state enum `aes_inv_state_t`;
  - constants NR=10, NK=4;
  - the `RCON[1:10]` byte table;
  - functions `xtime`, `gmul` (for the 0x09/0x0B/0x0D/0x0E multipliers), `inv_shift_rows` and `inv_mix_column`.
- Sub-module `inv_s_box`: 32-bit in, 32-bit out, four inverse-S-box byte lookups.
  - Instantiated 4 times to cover the 128-bit state.
- The existing `s_box` is reused for SubWord in key expansion.

## Test plan
- FIPS-197 C.1:
  - Stimulus: key 000102030405060708090a0b0c0d0e0f, ct 69c4e0d86a7b0430d8cdb78070b4c55a.
  - Expected: `done` at T+59; w40..w43 = 13111d7f e3944a17 f307a78b 4d2b30c5; readout 00112233 44556677 8899aabb ccddeeff.
- FIPS-197 B:
  - Stimulus: key 2b7e151628aed2a6abf7158809cf4f3c, ct 3925841d02dc09fbdc118597196a0b32.
  - Expected: w40..w43 = d014f9a8 c9ee2589 e13f0cc8 b6630ca6; plaintext 3243f6a8 885a308d 313198a2 e0370734.
- Reset mid-ROUND (r==5) -> next cycle IDLE, `done`=0, `dword_out`=0. A following C.1 run is still correct.
- `start_n` and `start_read_n` pulsed during EXPAND and during READ -> ignored; cycle counts and outputs unchanged.
- In DONE, simultaneous `start_n`=0 and `start_read_n`=0 -> new load starts from that cycle's `dword_in`, no READ, `done` low next cycle.
- Back-to-back: the C.1 readout finishes at R+3, `start_n` is asserted at R+4, then the B vectors run -> correct plaintext and no stale key words.
